// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   ID-stage hazard controller. It watches the instruction in the IF/ID
//   latch and produces three controls:
//     - Data_stall : a RAW hazard was found against the in-flight
//                    destination scoreboard. IF/ID and PC hold.
//     - BJ_stall   : flush the IF/ID latch. It is held for FLUSH_CYCLES
//                    cycles after every branch or jump.
//     - PC_EN      : PC write enable.
//
// Parameters
//   DEPTH         in-flight destination slots (EX, MEM, WB by default), >= 1
//   FLUSH_CYCLES  BJ_stall pulse length per branch/jump, >= 2
//   NOP_INST      bubble word loaded on flush; never treated as a hazard source
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   EN           in   pipeline enable; 0 freezes all state and zeroes the outputs
//   ID_IR[31:0]  in   instruction currently in ID
//   Data_stall   out  RAW hazard stall
//   BJ_stall     out  branch/jump flush
//   PC_EN        out  EN & ~Data_stall & ~BJ_stall
//   stall_cycles[31:0] out  (HAZARD_PERF_CNT_EN only) count of Data_stall cycles
//   flush_cycles[31:0] out  (HAZARD_PERF_CNT_EN only) count of BJ_stall cycles
//
// Build option: define HAZARD_PERF_CNT_EN to add the two performance counters.
module hazard_stall_ctrl #(
   parameter int          DEPTH        = 3,
   parameter int          FLUSH_CYCLES = 3,
   parameter logic [31:0] NOP_INST     = 32'h0000_2003
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [31:0] ID_IR,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles,
`endif
   output logic        Data_stall,
   output logic        BJ_stall,
   output logic        PC_EN
);

   localparam int CW = $clog2(FLUSH_CYCLES);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [DEPTH-1:0]        slot_vld;
   logic [DEPTH-1:0][4:0]   slot_rd;

   // ---------------- decode ----------------
   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   logic       is_nop, use_rs1, use_rs2, writes_rd, is_bj, hazard;

   assign opcode = ID_IR[6:0];
   assign rs1    = ID_IR[19:15];
   assign rs2    = ID_IR[24:20];
   assign rd     = ID_IR[11:7];
   assign is_nop = (ID_IR == NOP_INST) || (ID_IR == 32'd0);

   always_comb begin
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
      is_bj     = 1'b0;
      if (!is_nop) begin
         case (opcode)
            7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; end
            7'b0010011,
            7'b0000011: begin use_rs1 = 1'b1; writes_rd = 1'b1; end
            7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_bj = 1'b1; end
            7'b1100111: begin use_rs1 = 1'b1; writes_rd = 1'b1; is_bj = 1'b1; end
            7'b1101111: begin writes_rd = 1'b1; is_bj = 1'b1; end
            7'b0110111,
            7'b0010111: writes_rd = 1'b1;
            default:    ;
         endcase
      end
      // x0 is hard-wired, so it can never carry a dependency
      use_rs1 = use_rs1 && (rs1 != 5'd0);
      use_rs2 = use_rs2 && (rs2 != 5'd0);
   end

   // ---------------- RAW check against every in-flight slot ----------------
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_vld[i] && ((use_rs1 && rs1 == slot_rd[i]) ||
                             (use_rs2 && rs2 == slot_rd[i])))
            hazard = 1'b1;
      end
   end

   // Data_stall wins over branch detect; while flushing, ID_IR is ignored.
   assign Data_stall = EN && (state == IDLE) && hazard;
   assign BJ_stall   = EN && ((state == FLUSH) || (is_bj && !Data_stall));
   assign PC_EN      = EN && !Data_stall && !BJ_stall;

   // ---------------- scoreboard + flush FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld <= '0;
         slot_rd  <= '0;
         state    <= IDLE;
         cnt      <= '0;
      end else if (EN) begin
         for (int i = DEPTH-1; i > 0; i--) begin
            slot_vld[i] <= slot_vld[i-1];
            slot_rd[i]  <= slot_rd[i-1];
         end
         // A stalled or flushed instruction does not advance, so it inserts a bubble.
         slot_vld[0] <= writes_rd && (rd != 5'd0) && !Data_stall && (state == IDLE);
         slot_rd[0]  <= rd;

         case (state)
            IDLE: if (BJ_stall) begin
               // This cycle is the first flush cycle; FLUSH covers the remainder.
               cnt   <= CW'(FLUSH_CYCLES - 1);
               state <= FLUSH;
            end
            FLUSH: if (cnt == CW'(1)) state <= IDLE;
                   else               cnt   <= cnt - CW'(1);
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (Data_stall) stall_cycles <= stall_cycles + 32'd1;
         if (BJ_stall)   flush_cycles <= flush_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Each step drives one cycle of inputs
// and queues the expected {Data_stall, BJ_stall, PC_EN}. The queued value is
// popped and compared on the following falling edge.
module tb_hazard_stall_ctrl;
   localparam logic [31:0] NOP      = 32'h0000_2003;
   localparam logic [31:0] ADD_X5   = 32'h002082B3; // add x5,x1,x2
   localparam logic [31:0] ADD_X6   = 32'h00328333; // add x6,x5,x3
   localparam logic [31:0] BEQ_12   = 32'h00208463; // beq x1,x2,+8
   localparam logic [31:0] BEQ_52   = 32'h00228463; // beq x5,x2,+8
   localparam logic [31:0] ADDI_X0  = 32'h00100013; // addi x0,x0,1
   localparam logic [31:0] ADD_X7   = 32'h000003B3; // add x7,x0,x0

   logic        clk = 1'b0;
   logic        rst, EN;
   logic [31:0] ID_IR;
   logic        Data_stall, BJ_stall, PC_EN;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   int n_cmp = 0;
   int n_mis = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk(clk), .rst(rst), .EN(EN), .ID_IR(ID_IR),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
      .Data_stall(Data_stall), .BJ_stall(BJ_stall), .PC_EN(PC_EN)
   );

   // exp = {Data_stall, BJ_stall, PC_EN}
   task automatic step(input logic r, input logic en, input logic [31:0] ir,
                       input logic [2:0] exp, input string tag);
      logic [2:0] want, got;
      rst = r; EN = en; ID_IR = ir;
      exp_q.push_back(exp);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {Data_stall, BJ_stall, PC_EN};
      n_cmp++;
      assert (got === want) else begin
         n_mis++;
         $error("FAIL %s: got ds/bj/pc=%b want %b", tag, got, want);
      end
      @(posedge clk); #1;
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic chk32(input logic [31:0] got, input logic [31:0] want, input string tag);
      n_cmp++;
      assert (got === want) else begin
         n_mis++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; EN = 1'b1; ID_IR = 32'd0;
      @(posedge clk); #1;
      // T1 reset
      step(1, 1, 32'd0, 3'b001, "t1_rst");
      step(0, 1, 32'd0, 3'b001, "t1_idle");
      step(0, 1, ADD_X6, 3'b001, "t1_sb_empty");
      for (int i = 0; i < 3; i++) step(0, 1, NOP, 3'b001, "t1_drain");
      // T2 RAW: exactly 3 stall cycles
      step(0, 1, ADD_X5, 3'b001, "t2_producer");
      for (int i = 0; i < 3; i++) step(0, 1, ADD_X6, 3'b100, "t2_stall");
      step(0, 1, ADD_X6, 3'b001, "t2_release");
      // T4 x0 never matches
      step(0, 1, ADDI_X0, 3'b001, "t4_addi_x0");
      step(0, 1, ADD_X7,  3'b001, "t4_add_x0x0");
      step(0, 1, ADD_X7,  3'b001, "t4_add_x0x0_again");
      for (int i = 0; i < 3; i++) step(0, 1, NOP, 3'b001, "t4_drain");
      // T3 branch: 3 flush cycles
      step(0, 1, BEQ_12, 3'b010, "t3_bj_first");
      for (int i = 0; i < 2; i++) step(0, 1, NOP, 3'b010, "t3_flush");
      step(0, 1, NOP, 3'b001, "t3_idle");
      // T5 priority: stall then flush, never both
      step(0, 1, ADD_X5, 3'b001, "t5_producer");
      for (int i = 0; i < 3; i++) step(0, 1, BEQ_52, 3'b100, "t5_stall");
      step(0, 1, BEQ_52, 3'b010, "t5_bj_first");
      for (int i = 0; i < 2; i++) step(0, 1, NOP, 3'b010, "t5_flush");
      step(0, 1, NOP, 3'b001, "t5_idle");
      // EN=0 freezes scoreboard: stall still lasts 3 enabled cycles
      step(0, 1, ADD_X5, 3'b001, "en_producer");
      for (int i = 0; i < 2; i++) step(0, 0, ADD_X6, 3'b000, "en_off_stall");
      for (int i = 0; i < 3; i++) step(0, 1, ADD_X6, 3'b100, "en_stall");
      step(0, 1, ADD_X6, 3'b001, "en_release");
      for (int i = 0; i < 3; i++) step(0, 1, NOP, 3'b001, "en_drain");
      // EN=0 freezes flush counter
      step(0, 1, BEQ_12, 3'b010, "en_bj_first");
      for (int i = 0; i < 2; i++) step(0, 0, NOP, 3'b000, "en_off_flush");
      for (int i = 0; i < 2; i++) step(0, 1, NOP, 3'b010, "en_flush");
      step(0, 1, NOP, 3'b001, "en_flush_done");
`ifdef HAZARD_PERF_CNT_EN
      chk32(stall_cycles, 32'd9, "perf_stall");
      chk32(flush_cycles, 32'd9, "perf_flush");
`endif
      // T6 rst during the 2nd flush cycle aborts the flush
      step(0, 1, BEQ_12, 3'b010, "t6_bj_first");
      step(1, 1, NOP,    3'b010, "t6_rst_in_flush");
      step(0, 1, NOP,    3'b001, "t6_abort");
`ifdef HAZARD_PERF_CNT_EN
      chk32(stall_cycles, 32'd0, "t6_perf_stall_clr");
      chk32(flush_cycles, 32'd0, "t6_perf_flush_clr");
`endif
      step(0, 1, NOP, 3'b001, "t6_idle");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
